// File: rtl/dla_requan2_pkg.sv
// Shared widths, saturation limits, per-stage beat structs and the int8 clamp
// used by the second requantization stage.
package dla_requan2_pkg;

  localparam int IN_W    = 16;
  localparam int SCALE_W = 16;
  localparam int SHIFT_W = 5;
  localparam int OUT_W   = 8;
  localparam int CNT_W   = 16;

  // 16x17 signed product needs 33 bits; the zero-point add needs one more.
  localparam int P_W = 33;
  localparam int Z_W = 34;

  localparam logic signed [OUT_W-1:0] OUT_MAX = 8'sd127;
  localparam logic signed [OUT_W-1:0] OUT_MIN = -8'sd128;

  typedef struct packed {
    logic signed [IN_W-1:0] data;
    logic [SCALE_W-1:0]     scale;
    logic [SHIFT_W-1:0]     shift;
    logic                   last;
    logic                   bypass;
  } beat_t;

  typedef struct packed {
    logic signed [P_W-1:0] prod;
    logic [SHIFT_W-1:0]    shift;
    logic                  last;
  } s1_t;

  typedef struct packed {
    logic signed [P_W-1:0] res;
    logic                  last;
  } s2_t;

  typedef struct packed {
    logic signed [OUT_W-1:0] data;
    logic                    last;
  } s3_t;

  function automatic logic is_sat(input logic signed [Z_W-1:0] v);
    return (v > 34'sd127) || (v < -34'sd128);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat8(input logic signed [Z_W-1:0] v);
    if (v > 34'sd127)       return OUT_MAX;
    else if (v < -34'sd128) return OUT_MIN;
    else                    return v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/dla_requan2_if.sv
// Input and output streams of the requantizer. The slave modport is the
// requantizer's view; master is the view of whatever drives and drains it.
interface dla_requan2_if;
  import dla_requan2_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic signed [IN_W-1:0]    in_data;
  logic [SCALE_W-1:0]        in_scale;
  logic [SHIFT_W-1:0]        in_shift;
  logic                      in_last;

  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   out_data;
  logic                      out_last;

  modport slave (
    input  in_valid, in_data, in_scale, in_shift, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_scale, in_shift, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/dla_requan2_pipe_reg.sv
// Generic one-deep valid/ready register slice. Loads when empty or when the
// downstream side takes the current beat; data only changes on a real load so
// the output holds steady under backpressure.
module dla_requan2_pipe_reg #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Advance the slice; synchronous reset empties it and clears the payload.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/dla_requan2.sv
// Second requantization stage: multiply by scale, round-half-up shift,
// add zero point, clamp to int8. Three register slices, full backpressure,
// plus a saturating count of clamped beats for debug.
module dla_requan2
  import dla_requan2_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  dla_requan2_if.slave            bus,
  input  logic                    i_do_requan,
  input  logic signed [OUT_W-1:0] i_zero_point,
  input  logic                    i_sat_clr,
  output logic [CNT_W-1:0]        o_sat_cnt
);

  beat_t                   w_beat;
  s1_t                     w_s1_d, w_s1_q;
  s2_t                     w_s2_d, w_s2_q;
  s3_t                     w_s3_d, w_s3_q;
  logic                    w_s1_ready, w_s2_ready, w_s3_ready;
  logic                    w_s1_valid, w_s2_valid, w_s3_valid;
  logic signed [P_W-1:0]   w_rnd;
  logic signed [P_W-1:0]   w_sum;
  logic signed [Z_W-1:0]   w_z;
  logic                    w_sat;
  logic                    w_s3_load;
  logic [CNT_W-1:0]        r_sat_cnt;

  assign w_beat = '{data:   bus.in_data,
                    scale:  bus.in_scale,
                    shift:  bus.in_shift,
                    last:   bus.in_last,
                    bypass: !i_do_requan};

  // S1 input: product, or the raw value with zero shift when bypassing, so
  // the bypass decision rides with the beat through the later stages.
  always_comb begin
    w_s1_d.last = w_beat.last;
    if (w_beat.bypass) begin
      w_s1_d.prod  = P_W'($signed(w_beat.data));
      w_s1_d.shift = '0;
    end else begin
      w_s1_d.prod  = P_W'($signed(w_beat.data)) * P_W'($signed({1'b0, w_beat.scale}));
      w_s1_d.shift = w_beat.shift;
    end
  end

  // S2 input: add half an LSB of the result, then arithmetic shift (floor),
  // giving round-half-up toward +inf.
  always_comb begin
    w_rnd = '0;
    if (w_s1_q.shift != '0) w_rnd = P_W'(1) << (w_s1_q.shift - 1'b1);
    w_sum       = $signed(w_s1_q.prod) + w_rnd;
    w_s2_d.res  = w_sum >>> w_s1_q.shift;
    w_s2_d.last = w_s1_q.last;
  end

  // S3 input: zero-point offset and int8 clamp.
  always_comb begin
    w_z         = Z_W'($signed(w_s2_q.res)) + Z_W'(i_zero_point);
    w_s3_d.data = sat8(w_z);
    w_s3_d.last = w_s2_q.last;
    w_sat       = is_sat(w_z);
  end

  dla_requan2_pipe_reg #(.W($bits(s1_t))) u_s1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_valid(bus.in_valid), .o_ready(w_s1_ready), .i_data(w_s1_d),
    .o_valid(w_s1_valid), .o_data(w_s1_q), .i_ready(w_s2_ready)
  );

  dla_requan2_pipe_reg #(.W($bits(s2_t))) u_s2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_valid(w_s1_valid), .o_ready(w_s2_ready), .i_data(w_s2_d),
    .o_valid(w_s2_valid), .o_data(w_s2_q), .i_ready(w_s3_ready)
  );

  dla_requan2_pipe_reg #(.W($bits(s3_t))) u_s3 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_valid(w_s2_valid), .o_ready(w_s3_ready), .i_data(w_s3_d),
    .o_valid(w_s3_valid), .o_data(w_s3_q), .i_ready(bus.out_ready)
  );

  assign bus.in_ready  = w_s1_ready;
  assign bus.out_valid = w_s3_valid;
  assign bus.out_data  = w_s3_q.data;
  assign bus.out_last  = w_s3_q.last;

  // A beat is counted once, on the edge it enters S3, never while it waits.
  assign w_s3_load = w_s2_valid && w_s3_ready;

  // Saturation counter: clear wins, sticks at all-ones.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sat_cnt <= '0;
    end else if (i_sat_clr) begin
      r_sat_cnt <= '0;
    end else if (w_s3_load && w_sat && (r_sat_cnt != '1)) begin
      r_sat_cnt <= r_sat_cnt + 1'b1;
    end
  end

  assign o_sat_cnt = r_sat_cnt;

endmodule

// File: doc/dla_requan2.md
Name: dla_requan2

Overview:
- Second requantization stage of the DLA post-processing chain. Sits directly downstream of the bias-subtract/saturate stage and consumes its signed 16-bit result stream.
- Applies a per-element fixed-point rescale: multiply by an unsigned 16-bit scale, round-half-up arithmetic right shift, add an output zero point, then saturate to int8.
- Output is an int8 stream for the output-buffer writer.
- 3-stage valid/ready pipeline with full backpressure. Also keeps a saturation-event counter for debug.

Parameters:
- IN_W, 16, input data width (signed; equals `HWORD).
- SCALE_W, 16, scale multiplier width (unsigned).
- SHIFT_W, 5, shift amount width (0..31).
- OUT_W, 8, output width (signed).
- CNT_W, 16, saturation counter width.

Ports:
- clk, input, 1, single clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, stage can accept a beat.
- in_data, input, IN_W, signed value from the bias-subtract stage.
- in_scale, input, SCALE_W, unsigned multiplier M; travels with the beat.
- in_shift, input, SHIFT_W, right shift s; travels with the beat.
- in_last, input, 1, last beat of tile; passed through.
- do_requan, input, 1, quasi-static; 0 = bypass rescale.
- zero_point, input, OUT_W, signed output offset; quasi-static.
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, consumer accepts.
- out_data, output, OUT_W, signed int8 result.
- out_last, output, 1, delayed in_last.
- sat_cnt, output, CNT_W, count of saturated output beats.
- sat_clr, input, 1, synchronous clear of sat_cnt.

Behaviour:
- Reset: rst_n sampled low on a clk edge clears all stage valid bits, out_data, out_last and sat_cnt to 0. in_ready = 1 after reset. A reset mid-stream drops in-flight beats; none are emitted afterwards.
- Pipeline: S1 registers product P = in_data * M as 33-bit signed (M zero-extended). S2 computes R = (P + (s ? 1<<(s-1) : 0)) >>> s as 33-bit signed. S3 computes Z = R + sign-extended zero_point and saturates to [-128, 127].
- Latency: 3 cycles from an accepted input to out_valid when there is no backpressure. Throughput: 1 beat/cycle.
- Stall rule: a stage advances when its successor is empty or advancing. out stage advances when !out_valid || out_ready. in_ready = !S1_valid || S1 advancing. No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready through the stall chain; this path is accepted.
- Handshake: out_data and out_last are held stable while out_valid && !out_ready. A beat transfers only when valid && ready on that edge.
- Bypass (do_requan = 0): the result is sat8(in_data + zero_point); M and s are ignored. Latency is still 3 cycles, with the decision carried down the pipeline per beat.
- Rounding: round-half-up toward +inf. s = 0 means no rounding term. s = 31 is legal.
- Saturation:
  - Z > 127 gives 127; Z < -128 gives -128.
  - Each saturated beat increments sat_cnt once, at its S3 load (not on repeats while stalled).
  - sat_cnt saturates at all-ones; it does not wrap.
  - sat_clr has priority over an increment in the same cycle.
- in_last is delayed alongside its beat.

Decomposition:
- Shared package dla_pkg: OUT_MIN/OUT_MAX constants, a struct for a pipeline beat (data, scale, shift, last, bypass), and a sat8 function.
- One natural sub-module: dla_pipe_reg, a generic valid/ready register slice instantiated per stage.

Test Plan:
- Rounding: M=16384, s=15, zp=0; in_data 100, 101, -101 -> out 50, 51, -50, each at cycle +3.
- Saturation: in_data 1000, M=32768, s=15 -> 127, sat_cnt=1. Then in_data -1000 -> -128, sat_cnt=2. Then sat_clr -> sat_cnt=0.
- Zero point: zp=-5, in_data 20, M=32768, s=15 -> 15. Bypass with in_data 300, zp=0 -> 127.
- Backpressure:
  - Stream 8 beats 0..7 with M=1<<8, s=8.
  - Hold out_ready low for cycles 4-9: in_ready drops once S1..S3 are full, and out_data stays stable.
  - Then out 0..7 emerge in order, no loss or duplication, out_last on beat 7 only.
- Random: random valid/ready toggling with 1000 beats against a reference model -> bit-exact match; sat_cnt equals the model count.
- Mid-stream reset: rst_n low for 1 cycle with 3 beats in flight -> out_valid=0, sat_cnt=0, in_ready=1 the next cycle, and no stale beat is emitted.
